// File: rtl/mem2_load_stage_pkg.sv
// Shared CPU types seen by the MEM2 stage: load descriptor, register write enables,
// exception class and the MEM2 load-tracking FSM states.
package CPU_Defines;

  typedef struct packed {
    logic       ReadMem;
    logic       Sign;
    logic [1:0] Size;
    logic [1:0] LR;
  } LoadType;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [1:0] LR_NONE = 2'b00;
  localparam logic [1:0] LR_LWR  = 2'b01;
  localparam logic [1:0] LR_LWL  = 2'b10;

  typedef struct packed {
    logic CP0Wr;
    logic HIWr;
    logic LOWr;
    logic RFWr;
  } RegsWrType;

  typedef struct packed {
    logic Interrupt;
    logic WrongAddressinIF;
    logic ReservedInstruction;
    logic CoprocessorUnusable;
    logic Overflow;
    logic Syscall;
    logic Break;
    logic Eret;
    logic WrWrongAddressinMEM;
    logic RdWrongAddressinMEM;
    logic Trap;
  } ExceptinPipeType;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } Mem2State_t;

endpackage

// File: rtl/mem2_load_stage_load_align.sv
// Combinational load formatter: picks the addressed byte/half, extends it, or merges
// an unaligned LWL/LWR word with rt. Zero latency, no flow control.
module load_align
  import CPU_Defines::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  a,
  input  LoadType     load_type,
  input  logic [31:0] rt,
  output logic [31:0] result
);

  logic [4:0]  sh_a;
  logic [4:0]  sh_l;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] lwl_keep;
  logic [31:0] lwr_keep;
  logic        unused_read_mem;

  // ~a equals 3-a for a two-bit offset
  assign sh_a     = {a, 3'b000};
  assign sh_l     = {~a, 3'b000};
  assign byte_v   = 8'(word >> sh_a);
  assign half_v   = a[1] ? word[31:16] : word[15:0];
  assign lwl_keep = ~(32'hFFFF_FFFF << sh_l);
  assign lwr_keep = ~(32'hFFFF_FFFF >> sh_a);

  assign unused_read_mem = load_type.ReadMem;

  always_comb begin
    result = word;
    case (load_type.LR)
      LR_LWL: result = (word << sh_l) | (rt & lwl_keep);
      LR_LWR: result = (word >> sh_a) | (rt & lwr_keep);
      default: begin
        case (load_type.Size)
          SIZE_BYTE: result = {{24{load_type.Sign & byte_v[7]}}, byte_v};
          SIZE_HALF: result = {{16{load_type.Sign & half_v[15]}}, half_v};
          default:   result = word;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mem2_load_stage.sv
// MEM2 stage: registers MEM results and waits for the outstanding D-cache load; result is
// combinational in the response cycle. Stalls while a live load or an orphaned response is due.
module mem2_load_stage
  import CPU_Defines::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  MEM2_Flush,
  input  logic                  MEM2_Wr,
  input  logic [DATA_WIDTH-1:0] MEM_PC,
  input  logic [DATA_WIDTH-1:0] MEM_ALUOut,
  input  logic [DATA_WIDTH-1:0] MEM_OutB,
  input  logic [DATA_WIDTH-1:0] MEM_Result,
  input  logic [4:0]            MEM_Dst,
  input  RegsWrType             MEM_RegsWrType,
  input  logic [1:0]            MEM_WbSel,
  input  LoadType               MEM_LoadType,
  input  ExceptinPipeType       MEM_ExcType,
  input  logic                  MEM_IsInDelaySlot,
  input  logic                  MEM_IsABranch,
  input  logic                  MEM_IsAImmeJump,
  input  logic                  MEM_ReqFired,
  input  logic                  dcache_rvalid,
  input  logic [DATA_WIDTH-1:0] dcache_rdata,
  output logic [DATA_WIDTH-1:0] MEM2_PC,
  output logic [DATA_WIDTH-1:0] MEM2_ALUOut,
  output logic [4:0]            MEM2_Dst,
  output RegsWrType             MEM2_RegsWrType,
  output ExceptinPipeType       MEM2_ExcType,
  output logic                  MEM2_IsInDelaySlot,
  output logic                  MEM2_IsABranch,
  output logic                  MEM2_IsAImmeJump,
  output logic [DATA_WIDTH-1:0] MEM2_Result,
  output logic                  MEM2_DataValid,
  output logic                  MEM2_Stall
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] alu_out;
    logic [DATA_WIDTH-1:0] out_b;
    logic [DATA_WIDTH-1:0] result;
    logic [4:0]            dst;
    RegsWrType             regs_wr;
    LoadType               load_type;
    ExceptinPipeType       exc;
    logic                  in_delay_slot;
    logic                  is_branch;
    logic                  is_imme_jump;
  } stage_t;

  Mem2State_t            state;
  Mem2State_t            state_nxt;
  stage_t                stage_q;
  stage_t                stage_d;
  logic [DATA_WIDTH-1:0] buf_q;
  logic [DATA_WIDTH-1:0] word;
  logic [DATA_WIDTH-1:0] load_value;
  logic                  load_done;
  logic                  capture;
  logic                  pend_in;
  logic                  rv_hit;
  logic                  unused_wb_sel;

  assign unused_wb_sel = ^MEM_WbSel;

  assign stage_d = '{
    pc:            MEM_PC,
    alu_out:       MEM_ALUOut,
    out_b:         MEM_OutB,
    result:        MEM_Result,
    dst:           MEM_Dst,
    regs_wr:       MEM_RegsWrType,
    load_type:     MEM_LoadType,
    exc:           MEM_ExcType,
    in_delay_slot: MEM_IsInDelaySlot,
    is_branch:     MEM_IsABranch,
    is_imme_jump:  MEM_IsAImmeJump
  };

  assign MEM2_Stall = ((state == WAIT) & ~dcache_rvalid) | (state == DROP);
  assign capture    = MEM2_Wr & ~MEM2_Stall & ~MEM2_Flush;
  assign pend_in    = MEM_LoadType.ReadMem & MEM_ReqFired & (MEM_ExcType == '0);
  assign rv_hit     = (state == WAIT) & dcache_rvalid;

  // A response arriving in WAIT frees the stage, so the next load may be captured in that cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (capture && pend_in) state_nxt = WAIT;
      WAIT: begin
        if (dcache_rvalid)   state_nxt = (capture && pend_in) ? WAIT : IDLE;
        else if (MEM2_Flush) state_nxt = DROP;
      end
      DROP: if (dcache_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)         stage_q <= '0;
    else if (MEM2_Flush) stage_q <= '0;
    else if (capture)    stage_q <= stage_d;
  end

  // Written even when flushed alongside the response; DROP-phase data never lands here.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     buf_q <= '0;
    else if (rv_hit) buf_q <= dcache_rdata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                    load_done <= 1'b0;
    else if (MEM2_Flush || capture) load_done <= 1'b0;
    else if (rv_hit)                load_done <= 1'b1;
  end

  assign word = rv_hit ? dcache_rdata : buf_q;

  load_align u_load_align (
    .word      (word),
    .a         (stage_q.alu_out[1:0]),
    .load_type (stage_q.load_type),
    .rt        (stage_q.out_b),
    .result    (load_value)
  );

  assign MEM2_PC            = stage_q.pc;
  assign MEM2_ALUOut        = stage_q.alu_out;
  assign MEM2_Dst           = stage_q.dst;
  assign MEM2_RegsWrType    = stage_q.regs_wr;
  assign MEM2_ExcType       = stage_q.exc;
  assign MEM2_IsInDelaySlot = stage_q.in_delay_slot;
  assign MEM2_IsABranch     = stage_q.is_branch;
  assign MEM2_IsAImmeJump   = stage_q.is_imme_jump;
  assign MEM2_Result        = stage_q.load_type.ReadMem ? load_value : stage_q.result;
  assign MEM2_DataValid     = ~stage_q.load_type.ReadMem | rv_hit | load_done;

  a_no_rvalid_in_idle: assert property (@(posedge clk) disable iff (!resetn)
    !((state == IDLE) && dcache_rvalid));

endmodule

// File: tb/tb_mem2_load_stage.sv
// Directed bench for mem2_load_stage: a transaction-level model predicts every output each
// cycle, and literal expectations pin the worked load/flush/reset cases.
module tb_mem2_load_stage;
  import CPU_Defines::*;

  typedef struct packed {
    logic [31:0]     pc;
    logic [31:0]     alu;
    logic [31:0]     outb;
    logic [31:0]     res;
    logic [4:0]      dst;
    RegsWrType       rw;
    logic [1:0]      wb;
    LoadType         lt;
    ExceptinPipeType exc;
    logic            ds;
    logic            br;
    logic            ij;
  } instr_t;

  logic            clk = 1'b0;
  logic            resetn = 1'b1;
  logic            flush = 1'b0;
  logic            wr = 1'b0;
  logic            req_fired = 1'b0;
  logic            rvalid = 1'b0;
  logic [31:0]     rdata = '0;
  instr_t          in_i = '0;

  logic [31:0]     o_pc, o_alu, o_res;
  logic [4:0]      o_dst;
  RegsWrType       o_rw;
  ExceptinPipeType o_exc;
  logic            o_ds, o_br, o_ij, o_dv, o_stall;

  int total = 0;
  int bad = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  mem2_load_stage #(.DATA_WIDTH(32)) dut (
    .clk                (clk),
    .resetn             (resetn),
    .MEM2_Flush         (flush),
    .MEM2_Wr            (wr),
    .MEM_PC             (in_i.pc),
    .MEM_ALUOut         (in_i.alu),
    .MEM_OutB           (in_i.outb),
    .MEM_Result         (in_i.res),
    .MEM_Dst            (in_i.dst),
    .MEM_RegsWrType     (in_i.rw),
    .MEM_WbSel          (in_i.wb),
    .MEM_LoadType       (in_i.lt),
    .MEM_ExcType        (in_i.exc),
    .MEM_IsInDelaySlot  (in_i.ds),
    .MEM_IsABranch      (in_i.br),
    .MEM_IsAImmeJump    (in_i.ij),
    .MEM_ReqFired       (req_fired),
    .dcache_rvalid      (rvalid),
    .dcache_rdata       (rdata),
    .MEM2_PC            (o_pc),
    .MEM2_ALUOut        (o_alu),
    .MEM2_Dst           (o_dst),
    .MEM2_RegsWrType    (o_rw),
    .MEM2_ExcType       (o_exc),
    .MEM2_IsInDelaySlot (o_ds),
    .MEM2_IsABranch     (o_br),
    .MEM2_IsAImmeJump   (o_ij),
    .MEM2_Result        (o_res),
    .MEM2_DataValid     (o_dv),
    .MEM2_Stall         (o_stall)
  );

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Byte-lane view of what each load kind returns.
  function automatic logic [31:0] ref_align(input logic [31:0] w, input int a, input LoadType lt,
                                            input logic [31:0] rt);
    logic [7:0] wb [4];
    logic [7:0] rb [4];
    logic [7:0] ob [4];
    int         x;
    for (int i = 0; i < 4; i++) begin
      wb[i] = w[8*i +: 8];
      rb[i] = rt[8*i +: 8];
      ob[i] = 8'h00;
    end
    if (lt.LR == LR_LWL) begin
      for (int i = 0; i < 4; i++) begin
        if (i < 3 - a) ob[i] = rb[i];
        else           ob[i] = wb[i - (3 - a)];
      end
      return {ob[3], ob[2], ob[1], ob[0]};
    end
    if (lt.LR == LR_LWR) begin
      for (int i = 0; i < 4; i++) begin
        if (i >= 4 - a) ob[i] = rb[i];
        else            ob[i] = wb[i + a];
      end
      return {ob[3], ob[2], ob[1], ob[0]};
    end
    if (lt.Size == SIZE_BYTE) begin
      x = lt.Sign ? int'($signed(wb[a])) : int'(wb[a]);
      return 32'(x);
    end
    if (lt.Size == SIZE_HALF) begin
      x = lt.Sign ? int'($signed({wb[2*(a/2)+1], wb[2*(a/2)]}))
                  : int'({wb[2*(a/2)+1], wb[2*(a/2)]});
      return 32'(x);
    end
    return w;
  endfunction

  // Model: the instruction held in MEM2, whether its load response is still owed, how many
  // responses are owed to squashed loads, and the last response delivered to a live load.
  instr_t      m_i = '0;
  bit          m_pend = 1'b0;
  bit          m_got = 1'b0;
  int          m_orph = 0;
  logic [31:0] m_buf = '0;

  always @(posedge clk or negedge resetn) begin
    bit stall_now;
    if (!resetn) begin
      m_i = '0; m_pend = 1'b0; m_got = 1'b0; m_orph = 0; m_buf = '0;
    end else begin
      stall_now = (m_pend && !rvalid) || (m_orph != 0);
      if (rvalid) begin
        if (m_orph != 0) m_orph--;
        else if (m_pend) begin
          m_buf = rdata; m_pend = 1'b0; m_got = 1'b1;
        end
      end
      if (flush) begin
        if (m_pend) m_orph++;
        m_i = '0; m_pend = 1'b0; m_got = 1'b0;
      end else if (wr && !stall_now) begin
        m_i    = in_i;
        m_pend = in_i.lt.ReadMem && req_fired && (in_i.exc == '0);
        m_got  = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    bit          e_hit, e_stall, e_dv;
    logic [31:0] e_word, e_res;
    if (cmp_en) begin
      e_hit   = m_pend && rvalid;
      e_stall = (m_pend && !rvalid) || (m_orph != 0);
      e_word  = e_hit ? rdata : m_buf;
      e_res   = m_i.lt.ReadMem ? ref_align(e_word, int'(m_i.alu[1:0]), m_i.lt, m_i.outb) : m_i.res;
      e_dv    = !m_i.lt.ReadMem || e_hit || m_got;
      chk32("m_pc", o_pc, m_i.pc);
      chk32("m_alu", o_alu, m_i.alu);
      chk32("m_dst", 32'(o_dst), 32'(m_i.dst));
      chk32("m_rw", 32'(o_rw), 32'(m_i.rw));
      chk32("m_exc", 32'(o_exc), 32'(m_i.exc));
      chk32("m_flags", {29'd0, o_ds, o_br, o_ij}, {29'd0, m_i.ds, m_i.br, m_i.ij});
      chk32("m_result", o_res, e_res);
      chk1("m_dv", o_dv, e_dv);
      chk1("m_stall", o_stall, e_stall);
    end
  end

  function automatic LoadType lt_of(input logic rm, input logic sg, input logic [1:0] sz,
                                    input logic [1:0] lr);
    LoadType t;
    t.ReadMem = rm; t.Sign = sg; t.Size = sz; t.LR = lr;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] outb,
                       input logic [31:0] res, input LoadType lt, input logic exc_on,
                       input logic fired);
    in_i              = '0;
    in_i.pc           = pc;
    in_i.alu          = alu;
    in_i.outb         = outb;
    in_i.res          = res;
    in_i.dst          = pc[6:2];
    in_i.rw           = 4'b0001;
    in_i.wb           = 2'b01;
    in_i.lt           = lt;
    in_i.exc.Overflow = exc_on;
    in_i.ds           = pc[2];
    in_i.br           = pc[3];
    in_i.ij           = pc[4];
    req_fired         = fired;
    wr                = 1'b1;
  endtask

  initial begin
    #200000;
    total++;
    bad++;
    $display("FAIL watchdog: bench still running at t=%0t, expected it to end", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int      n;
    LoadType lw;
    lw = lt_of(1'b1, 1'b0, SIZE_WORD, LR_NONE);
    #2 resetn = 1'b0;
    #1 cmp_en = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk1("rst_stall", o_stall, 1'b0);
    chk1("rst_dv", o_dv, 1'b1);
    chk32("rst_res", o_res, 32'h0);
    chk32("rst_pc", o_pc, 32'h0);
    tick(); resetn = 1'b1;

    // LW answered in its first MEM2 cycle
    issue(32'h100, 32'h1000, 32'h0, 32'h0, lw, 1'b0, 1'b1);
    tick(); wr = 1'b0; rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk1("lw_stall", o_stall, 1'b0);
    chk32("lw_res", o_res, 32'hDEAD_BEEF);
    chk1("lw_dv", o_dv, 1'b1);
    tick(); rvalid = 1'b0;
    @(negedge clk);
    chk32("lw_res_held", o_res, 32'hDEAD_BEEF);
    chk1("lw_dv_held", o_dv, 1'b1);
    tick();

    // LB signed at offset 3, response five cycles late; LHU captured in the response cycle
    issue(32'h104, 32'h2003, 32'h0, 32'h0, lt_of(1'b1, 1'b1, SIZE_BYTE, LR_NONE), 1'b0, 1'b1);
    tick(); wr = 1'b0;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (o_stall) n++;
      tick();
    end
    chk32("lb_stall_cycles", 32'(n), 32'd5);
    rvalid = 1'b1; rdata = 32'h80FF_FFFF;
    issue(32'h108, 32'h3002, 32'h0, 32'h0, lt_of(1'b1, 1'b0, SIZE_HALF, LR_NONE), 1'b0, 1'b1);
    @(negedge clk);
    chk1("lb_stall_resp", o_stall, 1'b0);
    chk32("lb_res", o_res, 32'hFFFF_FF80);
    tick(); wr = 1'b0; rdata = 32'h8001_1234;
    @(negedge clk);
    chk32("lhu_res", o_res, 32'h0000_8001);
    tick(); rvalid = 1'b0;

    // LWL / LWR at offset 1
    issue(32'h10C, 32'h4001, 32'h1122_3344, 32'h0, lt_of(1'b1, 1'b0, SIZE_WORD, LR_LWL), 1'b0, 1'b1);
    tick(); wr = 1'b0; rvalid = 1'b1; rdata = 32'hAABB_CCDD;
    @(negedge clk);
    chk32("lwl_res", o_res, 32'hCCDD_3344);
    tick(); rvalid = 1'b0;
    issue(32'h110, 32'h4001, 32'h1122_3344, 32'h0, lt_of(1'b1, 1'b0, SIZE_WORD, LR_LWR), 1'b0, 1'b1);
    tick(); wr = 1'b0; rvalid = 1'b1; rdata = 32'hAABB_CCDD;
    @(negedge clk);
    chk32("lwr_res", o_res, 32'h11AA_BBCC);
    tick(); rvalid = 1'b0;

    // Flush while waiting: orphan response two cycles later
    issue(32'h114, 32'h5000, 32'h0, 32'h0, lw, 1'b0, 1'b1);
    tick(); wr = 1'b0;
    @(negedge clk); chk1("fl_c1_stall", o_stall, 1'b1);
    tick(); flush = 1'b1;
    @(negedge clk); chk1("fl_c2_stall", o_stall, 1'b1);
    tick(); flush = 1'b0;
    @(negedge clk); chk1("fl_c3_stall", o_stall, 1'b1); chk32("fl_c3_pc", o_pc, 32'h0);
    tick(); rvalid = 1'b1; rdata = 32'h5555_5555;
    @(negedge clk); chk1("fl_c4_stall", o_stall, 1'b1);
    tick(); rvalid = 1'b0;
    @(negedge clk); chk1("fl_c5_stall", o_stall, 1'b0);

    // Exception-tagged loads stay idle; buffer still holds the LWR response word
    issue(32'h118, 32'h6000, 32'h0, 32'h0, lw, 1'b1, 1'b0);
    tick(); wr = 1'b0;
    @(negedge clk);
    chk1("exc_stall", o_stall, 1'b0);
    chk1("exc_ovf", o_exc.Overflow, 1'b1);
    chk32("exc_buf_kept", o_res, 32'hAABB_CCDD);
    issue(32'h11C, 32'h6004, 32'h0, 32'h0, lw, 1'b1, 1'b1);
    tick(); wr = 1'b0;
    @(negedge clk); chk1("exc_fired_stall", o_stall, 1'b0);

    // Next load receives its own data
    issue(32'h120, 32'h7000, 32'h0, 32'h0, lw, 1'b0, 1'b1);
    tick(); wr = 1'b0; rvalid = 1'b1; rdata = 32'h1234_5678;
    @(negedge clk); chk32("own_data", o_res, 32'h1234_5678);
    tick(); rvalid = 1'b0;

    // Flush together with the response: no DROP, data still lands in the buffer
    issue(32'h124, 32'h7004, 32'h0, 32'h0, lw, 1'b0, 1'b1);
    tick(); wr = 1'b0; flush = 1'b1; rvalid = 1'b1; rdata = 32'h0BAD_F00D;
    tick(); flush = 1'b0; rvalid = 1'b0;
    @(negedge clk);
    chk1("flrv_stall", o_stall, 1'b0);
    chk32("flrv_pc", o_pc, 32'h0);
    chk1("flrv_dv", o_dv, 1'b1);
    issue(32'h128, 32'h7008, 32'h0, 32'h0, lw, 1'b1, 1'b0);
    tick(); wr = 1'b0;
    @(negedge clk); chk32("flrv_buf", o_res, 32'h0BAD_F00D);

    // Flush beats a simultaneous capture
    issue(32'h12C, 32'h0, 32'h0, 32'h99, lt_of(1'b0, 1'b0, SIZE_BYTE, LR_NONE), 1'b0, 1'b0);
    flush = 1'b1;
    tick(); flush = 1'b0; wr = 1'b0;
    @(negedge clk);
    chk32("flcap_pc", o_pc, 32'h0);
    chk32("flcap_res", o_res, 32'h0);

    // Reset during WAIT, then a non-load passes its result through
    issue(32'h130, 32'h7010, 32'h0, 32'h0, lw, 1'b0, 1'b1);
    tick(); wr = 1'b0;
    @(negedge clk); chk1("rw_stall_pre", o_stall, 1'b1);
    tick(); resetn = 1'b0;
    @(negedge clk);
    chk1("rw_stall", o_stall, 1'b0);
    chk32("rw_pc", o_pc, 32'h0);
    chk32("rw_res", o_res, 32'h0);
    chk32("rw_regswr", 32'(o_rw), 32'h0);
    chk1("rw_dv", o_dv, 1'b1);
    tick(); resetn = 1'b1;
    issue(32'h134, 32'h0, 32'h0, 32'hCAFE_F00D, lt_of(1'b0, 1'b0, SIZE_BYTE, LR_NONE), 1'b0, 1'b0);
    tick(); wr = 1'b0;
    @(negedge clk);
    chk32("post_rst_res", o_res, 32'hCAFE_F00D);
    chk32("post_rst_pc", o_pc, 32'h134);
    chk1("post_rst_dv", o_dv, 1'b1);
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
